// File: rtl/fm_tx_pkg.sv
// rtl/fm_tx_pkg.sv - shared widths, carrier default and FSM states for the FM transmit path
package fm_tx_pkg;

    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int DEFAULT_PINC_W   = 40;

    localparam logic [DEFAULT_PINC_W-1:0] DEFAULT_CARRIER_PINC = 40'h0100000000;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } fm_state_e;

endpackage

// File: rtl/fm_interp.sv
// rtl/fm_interp.sv - linear interpolator between successive audio samples, one tick per 2^LOG2_DIV clocks
module fm_interp
    import fm_tx_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int LOG2_DIV = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable_i,
    input  logic                                prime_i,
    input  logic                                run_i,
    input  logic [SAMPLE_W-1:0]                 s_tdata_i,
    input  logic                                s_tvalid_i,
    output logic                                tick_o,
    output logic                                ready_o,
    output logic                                accept_o,
    output logic signed [SAMPLE_W+LOG2_DIV-1:0] cur_o
);

    localparam int CUR_W = SAMPLE_W + LOG2_DIV;

    logic signed [SAMPLE_W-1:0] target_q, target_d;
    logic signed [CUR_W-1:0]    cur_q, cur_d;
    logic signed [SAMPLE_W:0]   delta_q, delta_d;
    logic [LOG2_DIV-1:0]        cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] x;

    assign x        = s_tdata_i;
    assign tick_o   = run_i && (cnt_q == {LOG2_DIV{1'b1}});
    assign ready_o  = !reset && enable_i && (prime_i || tick_o);
    assign accept_o = ready_o && s_tvalid_i;
    assign cur_o    = cur_q;

    always_comb begin
        target_d = target_q;
        cur_d    = cur_q;
        delta_d  = delta_q;
        cnt_d    = cnt_q;
        if (!enable_i) begin
            cur_d   = '0;
            delta_d = '0;
            cnt_d   = '0;
        end else if (prime_i) begin
            if (accept_o) begin
                target_d = x;
                cur_d    = {x, {LOG2_DIV{1'b0}}};
                delta_d  = '0;
                cnt_d    = '0;
            end
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
            if (tick_o) begin
                // Reload from target so rounding in the ramp can never accumulate.
                cur_d = {target_q, {LOG2_DIV{1'b0}}};
                if (accept_o) begin
                    delta_d  = {x[SAMPLE_W-1], x} - {target_q[SAMPLE_W-1], target_q};
                    target_d = x;
                end else begin
                    delta_d = '0;
                end
            end else begin
                cur_d = cur_q + CUR_W'(delta_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            cur_q    <= '0;
            delta_q  <= '0;
            cnt_q    <= '0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            delta_q  <= delta_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fm_pinc_modulator.sv
// rtl/fm_pinc_modulator.sv - audio-driven FM phase-increment generator feeding the DDS
module fm_pinc_modulator
    import fm_tx_pkg::*;
#(
    parameter int                SAMPLE_W     = DEFAULT_SAMPLE_W,
    parameter int                PINC_W       = DEFAULT_PINC_W,
    parameter int                LOG2_DIV     = 6,
    parameter int                DEV_SHIFT    = 8,
    parameter logic [PINC_W-1:0] CARRIER_PINC = DEFAULT_CARRIER_PINC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] s_audio_tdata,
    input  logic                s_audio_tvalid,
    output logic                s_audio_tready,
    output logic [PINC_W-1:0]   m_pinc_tdata,
    output logic                m_pinc_tvalid,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    localparam int CUR_W = SAMPLE_W + LOG2_DIV;

    if (SAMPLE_W + LOG2_DIV + DEV_SHIFT > PINC_W) begin : g_width_check
        $fatal(1, "fm_pinc_modulator: SAMPLE_W+LOG2_DIV+DEV_SHIFT exceeds PINC_W");
    end

    fm_state_e                 state_q;
    logic [PINC_W-1:0]         pinc_q, pinc_d;
    logic                      pvalid_q;
    logic                      underrun_q;
    logic [7:0]                ucnt_q;
    logic                      tick, accept;
    logic signed [CUR_W-1:0]   cur;
    logic signed [PINC_W-1:0]  cur_ext;

    fm_interp #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_DIV (LOG2_DIV)
    ) u_interp (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable),
        .prime_i    (state_q == PRIME),
        .run_i      (state_q == RUN),
        .s_tdata_i  (s_audio_tdata),
        .s_tvalid_i (s_audio_tvalid),
        .tick_o     (tick),
        .ready_o    (s_audio_tready),
        .accept_o   (accept),
        .cur_o      (cur)
    );

    // Deviation wraps modulo 2^PINC_W, matching the DDS phase accumulator.
    assign cur_ext = PINC_W'(cur);
    assign pinc_d  = CARRIER_PINC + (cur_ext << DEV_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pinc_q     <= CARRIER_PINC;
            pvalid_q   <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else if (!enable) begin
            state_q  <= IDLE;
            pinc_q   <= CARRIER_PINC;
            pvalid_q <= 1'b0;
        end else begin
            pinc_q   <= CARRIER_PINC;
            pvalid_q <= 1'b0;
            case (state_q)
                IDLE:  state_q <= PRIME;
                PRIME: if (accept) state_q <= RUN;
                RUN: begin
                    pvalid_q <= 1'b1;
                    pinc_q   <= pinc_d;
                    if (tick && !s_audio_tvalid) begin
                        underrun_q <= 1'b1;
                        if (ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_pinc_tdata  = pinc_q;
    assign m_pinc_tvalid = pvalid_q;
    assign underrun      = underrun_q;
    assign underrun_cnt  = ucnt_q;

endmodule
